iso16_true_delivery_loop: RTL and testbench

//  ISO-16 True Delivery Loop core: sits directly upstream of the waveform logger and drives all of its inputs.

---
 rtl/iso16_true_delivery_loop_if.sv | 29 ++
 rtl/iso16_true_delivery_loop.sv | 204 ++++++++++++++++++++
 tb/tb_iso16_true_delivery_loop.sv | 254 +++++++++++++++++++++++++
 3 files changed

// File: rtl/iso16_true_delivery_loop_if.sv
// rtl/iso16_true_delivery_loop_if.sv - sample stream bundle for the ISO-16 true delivery loop
// Purpose: carries one batch sample per s_valid/s_ready handshake into the loop core.
// Signals:
//   s_valid              sample valid (master -> slave)
//   s_ready              sample accepted when s_valid && s_ready (slave -> master)
//   s_last               final sample of the batch
//   s_warp_x/y/z         signed warp components, WARP_WIDTH bits
//   s_error              unsigned 16-bit error term
interface iso16_true_delivery_loop_if #(
    parameter int WARP_WIDTH = 16
) ();
    logic                  s_valid;
    logic                  s_ready;
    logic                  s_last;
    logic [WARP_WIDTH-1:0] s_warp_x;
    logic [WARP_WIDTH-1:0] s_warp_y;
    logic [WARP_WIDTH-1:0] s_warp_z;
    logic [15:0]           s_error;

    modport master (
        output s_valid, s_last, s_warp_x, s_warp_y, s_warp_z, s_error,
        input  s_ready
    );

    modport slave (
        input  s_valid, s_last, s_warp_x, s_warp_y, s_warp_z, s_error,
        output s_ready
    );
endinterface

// File: rtl/iso16_true_delivery_loop.sv
// rtl/iso16_true_delivery_loop.sv - ISO-16 true delivery loop core
// Purpose: accumulates a streamed batch of warp vectors and error terms, checks
// symmetry and error budget, and on true delivery requests a seal from an
// external seal engine and latches the returned 256-bit value.
// Ports:
//   clk, rst         clock (rising edge) and asynchronous active-high reset
//   start            begin a batch; honoured only in IDLE or DONE
//   smp              sample stream (slave side of iso16_true_delivery_loop_if)
//   state            FSM state code (IDLE=0 .. DONE=7)
//   warp_sum_x/y/z   modular warp accumulators
//   error_sum        saturating error accumulator
//   symmetry_ok      registered pairwise symmetry result
//   error_ok         registered error budget result
//   true_delivery    symmetry_ok && error_ok
//   seal_start       one-cycle request to the seal engine
//   seal_done        seal engine response strobe, seal_in valid with it
//   seal_ready       seal latched; held in DONE
//   seal             latched seal value
//   aborted          batch ended without a seal; held in DONE
module iso16_true_delivery_loop #(
    parameter int WARP_WIDTH   = 16,
    parameter int ERROR_WIDTH  = 32,
    parameter int SYM_TOL      = 0,
    parameter int ERROR_LIMIT  = 1000,
    parameter int SEAL_TIMEOUT = 1024
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    iso16_true_delivery_loop_if.slave    smp,
    output logic [2:0]                   state,
    output logic [WARP_WIDTH-1:0]        warp_sum_x,
    output logic [WARP_WIDTH-1:0]        warp_sum_y,
    output logic [WARP_WIDTH-1:0]        warp_sum_z,
    output logic [ERROR_WIDTH-1:0]       error_sum,
    output logic                         symmetry_ok,
    output logic                         error_ok,
    output logic                         true_delivery,
    output logic                         seal_start,
    input  logic                         seal_done,
    input  logic [255:0]                 seal_in,
    output logic                         seal_ready,
    output logic [255:0]                 seal,
    output logic                         aborted
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        ACCUM     = 3'd1,
        CHECK_SYM = 3'd2,
        CHECK_ERR = 3'd3,
        CHECK     = 3'd4,
        SEAL_REQ  = 3'd5,
        SEAL_WAIT = 3'd6,
        DONE      = 3'd7
    } state_t;

    localparam int TW = (SEAL_TIMEOUT > 1) ? $clog2(SEAL_TIMEOUT + 1) : 1;
    localparam logic [WARP_WIDTH:0]    TOL   = (WARP_WIDTH + 1)'(SYM_TOL);
    localparam logic [ERROR_WIDTH-1:0] LIMIT = ERROR_WIDTH'(ERROR_LIMIT);

    state_t         state_q, state_d;
    logic [TW-1:0]  tmo_cnt;

    logic           clear_c;
    logic           accept_c;
    logic           abort_c;
    logic           latch_c;

    // Modular difference a-b read as a signed value; magnitude kept one bit
    // wider so the most negative difference does not overflow.
    function automatic logic within_tol(input logic [WARP_WIDTH-1:0] a,
                                        input logic [WARP_WIDTH-1:0] b);
        logic [WARP_WIDTH-1:0] diff;
        logic [WARP_WIDTH:0]   ext;
        logic [WARP_WIDTH:0]   mag;
        diff = a - b;
        ext  = {diff[WARP_WIDTH-1], diff};
        mag  = ext[WARP_WIDTH] ? (~ext + 1'b1) : ext;
        return mag <= TOL;
    endfunction

    logic                   sym_c;
    logic [ERROR_WIDTH:0]   err_ext;
    logic [ERROR_WIDTH-1:0] err_next;

    always_comb begin
        sym_c = within_tol(warp_sum_x, warp_sum_y) &&
                within_tol(warp_sum_y, warp_sum_z) &&
                within_tol(warp_sum_x, warp_sum_z);
        err_ext  = {1'b0, error_sum} + (ERROR_WIDTH + 1)'(smp.s_error);
        // carry out of the accumulator means saturate to all-ones
        err_next = err_ext[ERROR_WIDTH] ? '1 : err_ext[ERROR_WIDTH-1:0];
    end

    assign state         = state_q;
    assign smp.s_ready   = (state_q == ACCUM);
    assign seal_start    = (state_q == SEAL_REQ);
    assign true_delivery = symmetry_ok && error_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        clear_c  = 1'b0;
        accept_c = 1'b0;
        abort_c  = 1'b0;
        latch_c  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    clear_c = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (smp.s_valid) begin
                    accept_c = 1'b1;
                    if (smp.s_last) begin
                        state_d = CHECK_SYM;
                    end
                end
            end
            CHECK_SYM: state_d = CHECK_ERR;
            CHECK_ERR: state_d = CHECK;
            CHECK: begin
                if (true_delivery) begin
                    state_d = SEAL_REQ;
                end else begin
                    abort_c = 1'b1;
                    state_d = DONE;
                end
            end
            SEAL_REQ: state_d = SEAL_WAIT;
            SEAL_WAIT: begin
                // a response in the expiry cycle still counts as delivered
                if (seal_done) begin
                    latch_c = 1'b1;
                    state_d = DONE;
                end else if (tmo_cnt == TW'(1)) begin
                    abort_c = 1'b1;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            warp_sum_x  <= '0;
            warp_sum_y  <= '0;
            warp_sum_z  <= '0;
            error_sum   <= '0;
            symmetry_ok <= 1'b0;
            error_ok    <= 1'b0;
            seal_ready  <= 1'b0;
            seal        <= '0;
            aborted     <= 1'b0;
            tmo_cnt     <= '0;
        end else begin
            if (clear_c) begin
                warp_sum_x  <= '0;
                warp_sum_y  <= '0;
                warp_sum_z  <= '0;
                error_sum   <= '0;
                symmetry_ok <= 1'b0;
                error_ok    <= 1'b0;
                seal_ready  <= 1'b0;
                seal        <= '0;
                aborted     <= 1'b0;
            end
            if (accept_c) begin
                warp_sum_x <= warp_sum_x + smp.s_warp_x;
                warp_sum_y <= warp_sum_y + smp.s_warp_y;
                warp_sum_z <= warp_sum_z + smp.s_warp_z;
                error_sum  <= err_next;
            end
            if (state_q == CHECK_SYM) begin
                symmetry_ok <= sym_c;
            end
            if (state_q == CHECK_ERR) begin
                error_ok <= (error_sum <= LIMIT);
            end
            if (state_q == SEAL_REQ) begin
                tmo_cnt <= TW'(SEAL_TIMEOUT);
            end else if (state_q == SEAL_WAIT && !seal_done) begin
                tmo_cnt <= tmo_cnt - 1'b1;
            end
            if (abort_c) begin
                aborted <= 1'b1;
            end
            if (latch_c) begin
                seal       <= seal_in;
                seal_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_iso16_true_delivery_loop.sv
// tb/tb_iso16_true_delivery_loop.sv - self-checking bench for iso16_true_delivery_loop
module tb_iso16_true_delivery_loop;
    localparam int W    = 16;
    localparam int EW   = 20;
    localparam int LIM  = 1000;
    localparam int TOUT = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           start;
    logic [2:0]     state;
    logic [W-1:0]   warp_sum_x, warp_sum_y, warp_sum_z;
    logic [EW-1:0]  error_sum;
    logic           symmetry_ok, error_ok, true_delivery;
    logic           seal_start, seal_done, seal_ready, aborted;
    logic [255:0]   seal_in, seal;

    always #5 clk = ~clk;

    iso16_true_delivery_loop_if #(.WARP_WIDTH(W)) smp ();

    iso16_true_delivery_loop #(
        .WARP_WIDTH(W), .ERROR_WIDTH(EW), .SYM_TOL(0),
        .ERROR_LIMIT(LIM), .SEAL_TIMEOUT(TOUT)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .smp(smp),
        .state(state), .warp_sum_x(warp_sum_x), .warp_sum_y(warp_sum_y),
        .warp_sum_z(warp_sum_z), .error_sum(error_sum),
        .symmetry_ok(symmetry_ok), .error_ok(error_ok),
        .true_delivery(true_delivery), .seal_start(seal_start),
        .seal_done(seal_done), .seal_in(seal_in), .seal_ready(seal_ready),
        .seal(seal), .aborted(aborted)
    );

    int errors = 0;
    int checks = 0;

    logic [15:0] qx[$], qy[$], qz[$], qe[$];

    task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_outs"}, {state, warp_sum_x, warp_sum_y, warp_sum_z, error_sum,
               symmetry_ok, error_ok, true_delivery, seal_start, seal_ready,
               aborted, smp.s_ready}, 256'd0);
        check({tag, "_seal"}, seal, 256'd0);
    endtask

    task automatic push(input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] z, input logic [15:0] e);
        qx.push_back(x); qy.push_back(y); qz.push_back(z); qe.push_back(e);
    endtask

    task automatic qclear();
        qx.delete(); qy.delete(); qz.delete(); qe.delete();
    endtask

    // |a-b| with the difference taken modulo 2^16 and read as signed
    function automatic int sdiff(input logic [15:0] a, input logic [15:0] b);
        int d;
        d = (int'(a) - int'(b) + 65536) % 65536;
        if (d >= 32768) d = d - 65536;
        return (d < 0) ? -d : d;
    endfunction

    // delay: SEAL_WAIT cycle index on which seal_done is returned; <0 = never
    task automatic run_batch(input int delay, input string tag);
        int          n, idx, guard, cnt, k, ax, ay, az;
        longint      ae;
        logic [15:0] ex, ey, ez;
        logic [EW-1:0] ee;
        logic        sym, eok, td, latched;
        logic [255:0] exp_seal;
        n = qx.size();
        ax = 0; ay = 0; az = 0; ae = 0;
        for (int i = 0; i < n; i++) begin
            ax += int'(qx[i]); ay += int'(qy[i]); az += int'(qz[i]); ae += longint'(qe[i]);
        end
        ex = ax[15:0]; ey = ay[15:0]; ez = az[15:0];
        ee = (ae > longint'((1 << EW) - 1)) ? '1 : ae[EW-1:0];
        sym = (sdiff(ex, ey) <= 0) && (sdiff(ey, ez) <= 0) && (sdiff(ex, ez) <= 0);
        eok = (ae <= LIM);
        td  = sym && eok;
        latched = td && delay >= 0 && delay < TOUT;
        exp_seal = '0;

        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        check({tag, "_accum_state"}, state, 3'd1);
        check({tag, "_cleared"}, {warp_sum_x, warp_sum_y, warp_sum_z, error_sum,
               aborted, seal_ready, seal}, 256'd0);

        idx = 0; guard = 0;
        while (idx < n && guard < 2000) begin
            if ($urandom_range(3) == 0) begin
                smp.s_valid = 1'b0;
                smp.s_warp_x = 16'($urandom); smp.s_warp_y = 16'($urandom);
                smp.s_warp_z = 16'($urandom); smp.s_error = 16'($urandom);
                smp.s_last = 1'($urandom_range(1));
            end else begin
                smp.s_valid = 1'b1;
                smp.s_warp_x = qx[idx]; smp.s_warp_y = qy[idx];
                smp.s_warp_z = qz[idx]; smp.s_error = qe[idx];
                smp.s_last = (idx == n - 1);
            end
            if (smp.s_valid && smp.s_ready) idx++;
            @(negedge clk);
            guard++;
        end
        smp.s_valid = 1'b0; smp.s_last = 1'b0;
        check({tag, "_stream_done"}, idx, n);
        check({tag, "_check_sym_state"}, state, 3'd2);
        check({tag, "_sums"}, {warp_sum_x, warp_sum_y, warp_sum_z}, {ex, ey, ez});
        check({tag, "_error_sum"}, error_sum, ee);

        cnt = 0;
        while (!(seal_start === 1'b1 || state == 3'd7) && cnt < 20) begin
            if (state == 3'd4) begin
                check({tag, "_flags"}, {symmetry_ok, error_ok, true_delivery}, {sym, eok, td});
            end
            @(negedge clk);
            cnt++;
        end
        check({tag, "_latency"}, cnt, 3);

        if (!td) begin
            check({tag, "_abort_state"}, state, 3'd7);
            check({tag, "_abort_flags"}, {aborted, seal_ready, seal_start}, 3'b100);
        end else begin
            check({tag, "_seal_req"}, {state, seal_start}, {3'd5, 1'b1});
            @(negedge clk);
            check({tag, "_seal_start_once"}, seal_start, 1'b0);
            k = 0;
            while (state == 3'd6 && k < 40) begin
                seal_done = (k == delay);
                if (seal_done) begin
                    for (int j = 0; j < 8; j++) seal_in[j*32 +: 32] = $urandom;
                    exp_seal = seal_in;
                end
                start = (k == 0 && delay != 0);
                @(negedge clk);
                seal_done = 1'b0; start = 1'b0;
                k++;
            end
            check({tag, "_wait_cycles"}, k, latched ? delay + 1 : TOUT);
            check({tag, "_done_state"}, state, 3'd7);
            check({tag, "_outcome"}, {seal_ready, aborted}, latched ? 2'b10 : 2'b01);
            check({tag, "_seal"}, seal, exp_seal);
        end

        // DONE holds everything and ignores a stray seal_done
        seal_done = 1'b1; seal_in = ~seal_in;
        @(negedge clk);
        seal_done = 1'b0;
        check({tag, "_hold"}, {state, warp_sum_x, true_delivery}, {3'd7, ex, td});
        check({tag, "_hold_seal"}, seal, exp_seal);
    endtask

    initial begin
        int n, mode, d;
        logic [15:0] v;
        rst = 1'b1; start = 1'b0; seal_done = 1'b0; seal_in = '0;
        smp.s_valid = 1'b1; smp.s_last = 1'b0;
        smp.s_warp_x = 16'd9; smp.s_warp_y = 16'd9; smp.s_warp_z = 16'd9; smp.s_error = 16'd9;
        repeat (3) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0; smp.s_valid = 1'b0;
        @(negedge clk);
        check_zero("reset_released");

        qclear(); repeat (4) push(16'd1, 16'd1, 16'd1, 16'd10);
        run_batch(2, "basic");
        check("basic_const", {warp_sum_x, warp_sum_y, warp_sum_z, error_sum, true_delivery},
              {16'd4, 16'd4, 16'd4, 20'd40, 1'b1});

        qclear(); repeat (3) push(16'd1, 16'd1, 16'd1, 16'd0); push(16'd1, 16'd1, 16'd2, 16'd0);
        run_batch(0, "asym");
        check("asym_const", {symmetry_ok, aborted, warp_sum_z}, {1'b0, 1'b1, 16'd5});

        qclear(); push(16'd7, 16'd7, 16'd7, 16'd500); push(16'd1, 16'd1, 16'd1, 16'd501);
        run_batch(1, "err1001");
        check("err1001_const", {error_ok, aborted}, 2'b01);
        qclear(); push(16'd7, 16'd7, 16'd7, 16'd500); push(16'd1, 16'd1, 16'd1, 16'd500);
        run_batch(1, "err1000");
        check("err1000_const", {error_ok, seal_ready}, 2'b11);

        qclear(); push(16'd2, 16'd2, 16'd2, 16'd1);
        run_batch(-1, "timeout");
        run_batch(TOUT - 1, "last_cycle_seal");
        run_batch(TOUT, "just_late");

        qclear(); push(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'd0); push(16'h0001, 16'h0001, 16'h0001, 16'd0);
        run_batch(0, "wrap");
        check("wrap_const", warp_sum_x, 16'h8000);

        qclear(); push(16'hFFFB, 16'hFFFB, 16'hFFFB, 16'd3);
        run_batch(4, "single");

        qclear(); repeat (17) push(16'd0, 16'd0, 16'd0, 16'hFFFF);
        run_batch(0, "saturate");
        check("saturate_const", error_sum, 20'hFFFFF);

        for (int b = 0; b < 6; b++) begin
            qclear();
            n = $urandom_range(1, 6);
            mode = $urandom_range(2);
            for (int i = 0; i < n; i++) begin
                v = 16'($urandom);
                if (mode == 0) push(16'($urandom), 16'($urandom), 16'($urandom), 16'($urandom_range(350)));
                else push(v, v, v, 16'($urandom_range(350)));
            end
            d = $urandom_range(9);
            run_batch(d, $sformatf("rand%0d", b));
        end

        // reset while waiting on the seal engine
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        smp.s_valid = 1'b1; smp.s_last = 1'b1;
        smp.s_warp_x = 16'd3; smp.s_warp_y = 16'd3; smp.s_warp_z = 16'd3; smp.s_error = 16'd1;
        @(negedge clk); smp.s_valid = 1'b0; smp.s_last = 1'b0;
        d = 0;
        while (state != 3'd6 && d < 20) begin @(negedge clk); d++; end
        check("rst_wait_reached", state, 3'd6);
        rst = 1'b1; #1;
        check_zero("rst_in_seal_wait");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check_zero("rst_seal_wait_after");

        // reset mid-batch with s_valid held high
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        smp.s_valid = 1'b1; smp.s_last = 1'b0;
        smp.s_warp_x = 16'd5; smp.s_warp_y = 16'd5; smp.s_warp_z = 16'd5; smp.s_error = 16'd2;
        @(negedge clk); @(negedge clk);
        check("midbatch_sum", {warp_sum_x, error_sum}, {16'd10, 20'd4});
        rst = 1'b1; #1;
        check_zero("rst_mid_batch");
        @(negedge clk); rst = 1'b0;
        @(negedge clk); @(negedge clk);
        check_zero("rst_mid_batch_after");
        smp.s_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
